// File: rtl/apb_master.sv
// APB requester bridge: turns a single-cycle host request into an APB
// SETUP/ACCESS transfer, returns read data / error status on a one-cycle ack,
// and aborts transfers that stall in ACCESS for TIMEOUT cycles.
module apb_master #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              req_rdy,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wd,
    output logic              ack,
    output logic [31:0]       rd,
    output logic              err,
    output logic              tout,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Counter only ever holds 0..TIMEOUT-1 (stalled ACCESS cycles seen so far).
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_rdy_q, req_rdy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              tout_q, tout_d;
    logic [31:0]       rd_q, rd_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;

    // Next-state and next-output computation; every output is a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_rdy_d = req_rdy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        tout_d    = 1'b0;
        rd_d      = rd_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    paddr_d   = addr;
                    pwrite_d  = we;
                    pwdata_d  = wd;
                    cnt_d     = '0;
                    psel_d    = 1'b1;
                    req_rdy_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout that would expire this cycle
                if (pready) begin
                    ack_d     = 1'b1;
                    err_d     = pslverr;
                    if (!pwrite_q) rd_d = prdata;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    req_rdy_d = 1'b1;
                    state_d   = IDLE;
                end else if ((TIMEOUT > 0) && (cnt_q == LIMIT)) begin
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    tout_d    = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    req_rdy_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                req_rdy_d = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_rdy_q <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            tout_q    <= 1'b0;
            rd_q      <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_rdy_q <= req_rdy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tout_q    <= tout_d;
            rd_q      <= rd_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign req_rdy = req_rdy_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign tout    = tout_q;
    assign rd      = rd_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign pwrite  = pwrite_q;
    assign psel    = psel_q;
    assign penable = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed transfers against a wait-state slave model,
// completions checked by a scoreboard monitor, phase timing checked inline.
module tb_apb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req_rdy;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rd;
    logic        err;
    logic        tout;
    logic [4:0]  paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    // slave behaviour for the current transfer
    int          cur_waits  = 0;
    logic [31:0] cur_prdata = '0;
    logic        cur_slverr = 1'b0;
    int          acc_cnt    = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic        tout;
    } resp_t;
    resp_t sb[$];

    apb_master #(.ADDR_W(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rdy(req_rdy), .we(we),
        .addr(addr), .wd(wd), .ack(ack), .rd(rd), .err(err), .tout(tout),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel),
        .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Slave: raise pready in the (cur_waits+1)-th ACCESS cycle.
    always @(negedge clk) begin
        prdata  = cur_prdata;
        pslverr = cur_slverr;
        if (psel && penable) begin
            pready  = (acc_cnt == cur_waits);
            acc_cnt = acc_cnt + 1;
        end else begin
            pready  = 1'b0;
            acc_cnt = 0;
        end
    end

    // Monitor: every ack must match the oldest expected response.
    always @(negedge clk) begin
        if (ack) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ack_unexpected actual=1 expected=0");
            end else begin
                resp_t e;
                e = sb.pop_front();
                chk("resp_rd",   {32'h0, rd}, {32'h0, e.rd});
                chk("resp_err",  {63'h0, err}, {63'h0, e.err});
                chk("resp_tout", {63'h0, tout}, {63'h0, e.tout});
            end
        end
    end

    // Issue one transfer starting at a negedge with req_rdy=1; returns at the
    // negedge of the ack cycle. hold keeps req high after acceptance.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] prd, input logic serr,
                        input int exp_acc, input logic [31:0] e_rd,
                        input logic e_err, input logic e_tout, input logic hold);
        int n;
        resp_t r;
        cur_waits  = waits;
        cur_prdata = prd;
        cur_slverr = serr;
        r.rd = e_rd; r.err = e_err; r.tout = e_tout;
        sb.push_back(r);
        req = 1'b1; we = w; addr = a; wd = d;
        @(negedge clk);
        if (!hold) req = 1'b0;
        chk("setup_phase", {61'h0, psel, penable, req_rdy}, 64'b100);
        chk("setup_addr", {27'h0, pwrite, paddr, pwdata}, {27'h0, w, a, d});
        n = 0;
        @(negedge clk);
        while (penable && n < 100) begin
            chk("access_stable", {27'h0, psel, paddr, pwdata}, {27'h0, 1'b1, a, d});
            n++;
            @(negedge clk);
        end
        chk("access_cycles", 64'(n), 64'(exp_acc));
        chk("ack_phase", {60'h0, ack, psel, penable, req_rdy}, 64'b1001);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", {58'h0, req_rdy, ack, err, tout, psel, penable}, 64'b100000);
        chk("reset_data", {26'h0, pwrite, paddr, rd}, 64'h0);
        chk("reset_pwdata", {32'h0, pwdata}, 64'h0);

        // zero-wait write; rd keeps its reset value
        xfer(1'b1, 5'h04, 32'h0000_00A5, 0, 32'h5555_5555, 1'b0, 1, 32'h0, 1'b0, 1'b0, 1'b0);
        // read with 3 wait states
        xfer(1'b0, 5'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 4, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        // slave error on read: data still captured
        xfer(1'b0, 5'h02, 32'h0, 0, 32'h0000_0012, 1'b1, 1, 32'h0000_0012, 1'b1, 1'b0, 1'b0);
        // timeout: pready never comes, rd unchanged
        xfer(1'b0, 5'h1F, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 16, 32'h0000_0012, 1'b1, 1'b1, 1'b0);
        // pready on the 16th ACCESS cycle: normal completion
        xfer(1'b0, 5'h0C, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 16, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
        // back-to-back with req held: write then read accepted in the ack cycle
        xfer(1'b1, 5'h00, 32'h1122_3344, 0, 32'h0, 1'b0, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1);
        xfer(1'b0, 5'h08, 32'h0, 2, 32'h0BAD_C0DE, 1'b0, 3, 32'h0BAD_C0DE, 1'b0, 1'b0, 1'b0);

        // reset during a wait state: no ack for the aborted transfer
        cur_waits = 1000;
        req = 1'b1; we = 1'b0; addr = 5'h06; wd = 32'h0;
        @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_access", {62'h0, psel, penable}, 64'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset", {60'h0, psel, penable, ack, req_rdy}, 64'b0001);
        chk("mid_reset_rd", {32'h0, rd}, 64'h0);
        @(negedge clk);
        // request after reset completes normally; rd was cleared by reset
        xfer(1'b1, 5'h03, 32'h0000_0077, 1, 32'h0, 1'b0, 2, 32'h0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
